// File: rtl/decode_stage.sv
// decode_stage: single-entry decode pipeline register between fetch and execute.
// Decodes RV32I fields and immediates, reads operands and stalls on load-use.
// Optional feature: define DECODE_WB_BYPASS_EN to forward the write-back port
// into the operands. Without it, a write-back to a used source stalls for one
// cycle so the register file can be re-read.
module decode_stage #(
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [4:0]  rf_read_reg1,
  output logic [4:0]  rf_read_reg2,
  input  logic [31:0] rf_read_data1,
  input  logic [31:0] rf_read_data2,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  input  logic        wb_write_enable,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [31:0] out_rs1_val,
  output logic [31:0] out_rs2_val,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rd,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic        out_illegal
);

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  // Sign-extended immediate by instruction format; R-type and unknown opcodes give 0.
  function automatic logic signed [31:0] imm_decode(input logic [31:0] ins);
    logic signed [31:0] imm;
    imm = '0;
    case (ins[6:0])
      OP_LOAD, OP_IMM, OP_JALR: imm = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:                 imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH:                imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:         imm = {ins[31:12], 12'h000};
      OP_JAL:                   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:                  imm = '0;
    endcase
    return imm;
  endfunction

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_STORE, OP_REG, OP_BRANCH,
      OP_JALR, OP_LUI, OP_AUIPC, OP_JAL: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

  logic [6:0]  dec_opcode;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        uses_rs1, uses_rs2;
  logic        load_hazard, wb_hazard, hazard, in_xfer;
  logic [31:0] rs1_val, rs2_val;

  logic        out_valid_q,   out_valid_d;
  logic [31:0] out_pc_q,      out_pc_d;
  logic [31:0] out_instr_q,   out_instr_d;
  logic [31:0] out_rs1_val_q, out_rs1_val_d;
  logic [31:0] out_rs2_val_q, out_rs2_val_d;
  logic signed [31:0] out_imm_q, out_imm_d;
  logic [4:0]  out_rd_q,      out_rd_d;
  logic [6:0]  out_opcode_q,  out_opcode_d;
  logic [2:0]  out_funct3_q,  out_funct3_d;
  logic [6:0]  out_funct7_q,  out_funct7_d;
  logic        out_illegal_q, out_illegal_d;

  assign dec_opcode   = in_instr[6:0];
  assign dec_rd       = in_instr[11:7];
  assign dec_rs1      = in_instr[19:15];
  assign dec_rs2      = in_instr[24:20];
  assign rf_read_reg1 = dec_rs1;
  assign rf_read_reg2 = dec_rs2;

  // Which source fields the opcode actually reads, and the resulting stall conditions.
  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (dec_opcode)
      OP_LOAD, OP_IMM, OP_JALR:    uses_rs1 = 1'b1;
      OP_STORE, OP_REG, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
    load_hazard = ex_is_load && (ex_rd != 5'd0) &&
                  ((uses_rs1 && (ex_rd == dec_rs1)) || (uses_rs2 && (ex_rd == dec_rs2)));
`ifdef DECODE_WB_BYPASS_EN
    wb_hazard = 1'b0;
`else
    wb_hazard = wb_write_enable &&
                ((uses_rs1 && (dec_rs1 != 5'd0) && (wb_write_reg == dec_rs1)) ||
                 (uses_rs2 && (dec_rs2 != 5'd0) && (wb_write_reg == dec_rs2)));
`endif
    hazard = in_valid && (load_hazard || wb_hazard);
  end

`ifndef DECODE_WB_BYPASS_EN
  // Write-back data is only consumed by the forwarding path.
  logic unused_wb_data;
  assign unused_wb_data = ^wb_write_data;
`endif

  // Operand selection: x0 always reads zero, forwarding overrides the register file.
  always_comb begin
    rs1_val = 32'd0;
    rs2_val = 32'd0;
    if (dec_rs1 != 5'd0) begin
      rs1_val = rf_read_data1;
`ifdef DECODE_WB_BYPASS_EN
      if (wb_write_enable && (wb_write_reg == dec_rs1)) rs1_val = wb_write_data;
`endif
    end
    if (dec_rs2 != 5'd0) begin
      rs2_val = rf_read_data2;
`ifdef DECODE_WB_BYPASS_EN
      if (wb_write_enable && (wb_write_reg == dec_rs2)) rs2_val = wb_write_data;
`endif
    end
  end

  assign in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
  assign in_xfer  = in_valid && in_ready;

  // Next state of the output register: flush, capture, drain to bubble, or hold.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_instr_d   = out_instr_q;
    out_rs1_val_d = out_rs1_val_q;
    out_rs2_val_d = out_rs2_val_q;
    out_imm_d     = out_imm_q;
    out_rd_d      = out_rd_q;
    out_opcode_d  = out_opcode_q;
    out_funct3_d  = out_funct3_q;
    out_funct7_d  = out_funct7_q;
    out_illegal_d = out_illegal_q;
    if (flush || (!in_xfer && out_ready)) begin
      out_valid_d = 1'b0;
      out_instr_d = BUBBLE_INSTR;
      out_rd_d    = 5'd0;
    end else if (in_xfer) begin
      out_valid_d   = 1'b1;
      out_pc_d      = in_pc;
      out_instr_d   = in_instr;
      out_rs1_val_d = rs1_val;
      out_rs2_val_d = rs2_val;
      out_imm_d     = imm_decode(in_instr);
      out_rd_d      = dec_rd;
      out_opcode_d  = dec_opcode;
      out_funct3_d  = in_instr[14:12];
      out_funct7_d  = in_instr[31:25];
      out_illegal_d = !opcode_legal(dec_opcode);
    end
  end

  // Output register; reset returns every field to its bubble value.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_instr_q   <= BUBBLE_INSTR;
      out_rs1_val_q <= '0;
      out_rs2_val_q <= '0;
      out_imm_q     <= '0;
      out_rd_q      <= '0;
      out_opcode_q  <= '0;
      out_funct3_q  <= '0;
      out_funct7_q  <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_instr_q   <= out_instr_d;
      out_rs1_val_q <= out_rs1_val_d;
      out_rs2_val_q <= out_rs2_val_d;
      out_imm_q     <= out_imm_d;
      out_rd_q      <= out_rd_d;
      out_opcode_q  <= out_opcode_d;
      out_funct3_q  <= out_funct3_d;
      out_funct7_q  <= out_funct7_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_instr   = out_instr_q;
  assign out_rs1_val = out_rs1_val_q;
  assign out_rs2_val = out_rs2_val_q;
  assign out_imm     = out_imm_q;
  assign out_rd      = out_rd_q;
  assign out_opcode  = out_opcode_q;
  assign out_funct3  = out_funct3_q;
  assign out_funct7  = out_funct7_q;
  assign out_illegal = out_illegal_q;

endmodule
